uart_telemetry_framer: RTL and testbench

//  Periodic N-channel telemetry framer feeding the uart_tx valid/ready byte interface. Snapshots
//  NUM_CH samples, emits SOF/count/data/[checksum]/EOF every PERIOD_CYC cycles. Echoes uart_rx

---
 rtl/uart_telemetry_framer.sv | 118 +++++++++++
 tb/tb_uart_telemetry_framer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_telemetry_framer.sv
// uart_telemetry_framer: periodic SOF/count/data/[CSUM]/EOF frames on a uart_tx byte stream, echoing uart_rx bytes between frames.
// Define TELEM_CHECKSUM_EN to insert the 8-bit sum of the count and data bytes before 0D 0A.
module uart_telemetry_framer #(
  parameter int         NUM_CH     = 2,
  parameter int         DATA_W     = 12,
  parameter int         PERIOD_CYC = 100_000_000,
  parameter logic [7:0] SOF0       = 8'hAA,
  parameter logic [7:0] SOF1       = 8'h55
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     frame_en,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_valid,
  output logic                     rx_data_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_data_ready,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     frame_overrun
);
`ifdef TELEM_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int         LEN   = 5 + 2*NUM_CH + CS;
  localparam int         CW    = $clog2(PERIOD_CYC);
  localparam logic [5:0] DLAST = 6'(2*NUM_CH + 2);
  localparam logic [5:0] LAST  = 6'(LEN - 1);
  typedef enum logic [1:0] {WAIT, ECHO, LOAD, SEND} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pending_q, pending_d, done_q, ovr_q, tick, last_acc;
  logic [5:0]             idx_q, idx_d;
  logic [4:0]             k;
  logic [7:0]             echo_q, echo_d, fbyte;
  logic [15:0]            samp;
  logic [NUM_CH-1:0][15:0] shadow_q;
`ifdef TELEM_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
  // Sum builds up as count and data bytes are accepted, so it is ready when its slot comes up.
  assign csum_d = state_q == LOAD ? 8'h00 :
                  (state_q == SEND && tx_data_ready && idx_q >= 6'd2 && idx_q <= DLAST) ? csum_q + fbyte : csum_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) csum_q <= '0;
    else csum_q <= csum_d;
`endif
  assign tick          = frame_en && cnt_q == CW'(PERIOD_CYC - 1);
  assign rx_data_ready = state_q == WAIT;
  assign tx_data_valid = state_q == ECHO || state_q == SEND;
  assign tx_data       = state_q == SEND ? fbyte : echo_q;
  assign frame_busy    = state_q == LOAD || state_q == SEND;
  assign frame_done    = done_q;
  assign frame_overrun = ovr_q;
  always_comb begin
    k = 5'(idx_q - 6'd3);
    samp = '0;
    for (int c = 0; c < NUM_CH; c++) if (k[4:1] == 4'(c)) samp = shadow_q[c];
    fbyte = idx_q == 6'd0 ? SOF0 :
            idx_q == 6'd1 ? SOF1 :
            idx_q == 6'd2 ? 8'(NUM_CH) :
            idx_q <= DLAST ? (k[0] ? samp[7:0] : samp[15:8]) :
`ifdef TELEM_CHECKSUM_EN
            idx_q == DLAST + 6'd1 ? csum_q :
`endif
            idx_q == LAST - 6'd1 ? 8'h0D : 8'h0A;
  end
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    echo_d    = echo_q;
    cnt_d     = (!frame_en || tick) ? '0 : cnt_q + 1'b1;
    pending_d = tick || (pending_q && state_q != LOAD);
    last_acc  = state_q == SEND && tx_data_ready && idx_q == LAST;
    case (state_q)
      // A pending or same-cycle tick beats an rx byte, which then waits upstream.
      WAIT: if (pending_q || tick) state_d = LOAD;
            else if (rx_data_valid) begin
              echo_d  = rx_data;
              state_d = ECHO;
            end
      ECHO: if (tx_data_ready) state_d = WAIT;
      LOAD: begin
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: if (tx_data_ready) begin
        idx_d   = idx_q + 6'd1;
        state_d = last_acc ? WAIT : SEND;
      end
      default: state_d = WAIT;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q   <= WAIT;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      echo_q    <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      echo_q    <= echo_d;
      done_q    <= last_acc;
      ovr_q     <= tick && pending_q && state_q != LOAD;
      if (state_q == LOAD)
        for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= 16'(ch_data[c*DATA_W +: DATA_W]);
    end
endmodule

// File: tb/tb_uart_telemetry_framer.sv
// tb_uart_telemetry_framer: directed frame vectors plus echo, stall, overrun, enable and reset sequences.
module tb_uart_telemetry_framer;
  localparam int P = 40;
  typedef struct {
    logic [11:0] c0;
    logic [11:0] c1;
    logic [7:0]  cs;
    int          stall_at;
  } vec_t;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b1, frame_en = 1'b0;
  logic        rx_data_valid = 1'b0, tx_data_ready = 1'b1;
  logic [23:0] ch_data = '0;
  logic [7:0]  rx_data = '0, tx_data;
  logic        rx_data_ready, tx_data_valid, frame_busy, frame_done, frame_overrun;
  int          checks = 0, failures = 0, dones = 0, ovrs = 0;
  logic [7:0]  q[$], exp_q[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = '0;
  vec_t        tbl[4];
  always #5 sys_clk = ~sys_clk;
  uart_telemetry_framer #(.NUM_CH(2), .DATA_W(12), .PERIOD_CYC(P)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ch_data(ch_data), .frame_en(frame_en),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  // Accepted bytes are logged at the falling edge; a stalled byte must hold value and valid.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (pv && !pr) begin
        chk("stall_valid", tx_data_valid, 1);
        chk("stall_data", tx_data, pd);
      end
      if (tx_data_valid && tx_data_ready) q.push_back(tx_data);
      if (frame_done) dones <= dones + 1;
      if (frame_overrun) ovrs <= ovrs + 1;
    end
    pv <= sys_rst_n && tx_data_valid;
    pr <= tx_data_ready;
    pd <= tx_data;
  end
  task automatic build_exp(input vec_t v);
    exp_q = '{8'hAA, 8'h55, 8'h02, {4'h0, v.c0[11:8]}, v.c0[7:0], {4'h0, v.c1[11:8]}, v.c1[7:0]};
`ifdef TELEM_CHECKSUM_EN
    exp_q.push_back(v.cs);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask
  task automatic cmp_frame(input string tag);
    chk($sformatf("%s_len", tag), q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
  endtask
  task automatic wait_busy(input string n, input int lim, output int cyc);
    cyc = 0;
    while (!frame_busy && cyc < lim) begin
      step();
      cyc++;
    end
    chk(n, frame_busy, 1);
  endtask
  task automatic wait_dones(input string n, input int target, input int lim);
    int c = 0;
    while (dones < target && c < lim) begin
      step();
      c++;
    end
    chk(n, dones >= target, 1);
  endtask
  task automatic drain();
    int idle = 0, c = 0;
    while (idle < 20 && c < 500) begin
      step();
      c++;
      idle = frame_busy ? 0 : idle + 1;
    end
    chk("drain_idle", idle, 20);
  endtask
  initial begin
    int cyc, d0, o0, c, nb;
    bit stalled;
    tbl[0] = '{12'h5A3, 12'h0FF, 8'hA9, -1};
    tbl[1] = '{12'hFFF, 12'h001, 8'h11, -1};
    tbl[2] = '{12'h000, 12'h000, 8'h02, -1};
    tbl[3] = '{12'h800, 12'h7FE, 8'h0F, 4};
    #2 sys_rst_n = 1'b0;
    repeat (3) step();
    chk("rst_tx_valid", tx_data_valid, 0);
    chk("rst_rx_ready", rx_data_ready, 1);
    chk("rst_busy", frame_busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", frame_overrun, 0);
    chk("rst_tx_data", tx_data, 0);
    sys_rst_n = 1'b1;
    frame_en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ch_data = {tbl[i].c1, tbl[i].c0};
      q.delete();
      d0 = dones;
      wait_busy($sformatf("v%0d_start", i), 3*P, cyc);
      if (i == 0) chk("first_frame_cyc", cyc, P);
      step();
      ch_data = ~ch_data;
      stalled = 0;
      c = 0;
      while (dones == d0 && c < 300) begin
        if (q.size() == tbl[i].stall_at && !stalled) begin
          tx_data_ready = 1'b0;
          repeat (50) step();
          tx_data_ready = 1'b1;
          stalled = 1;
        end
        step();
        c++;
      end
      chk($sformatf("v%0d_done_once", i), dones - d0, 1);
      build_exp(tbl[i]);
      cmp_frame($sformatf("v%0d", i));
    end
    frame_en = 1'b0;
    drain();
    q.delete();
    d0 = dones;
    chk("echo_rx_ready", rx_data_ready, 1);
    tx_data_ready = 1'b0;
    rx_data = 8'h3C;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
    chk("echo_valid", tx_data_valid, 1);
    chk("echo_data", tx_data, 8'h3C);
    chk("echo_rx_blocked", rx_data_ready, 0);
    repeat (5) step();
    tx_data_ready = 1'b1;
    repeat (3) step();
    chk("echo_count", q.size(), 1);
    chk("echo_byte", (q.size() > 0) ? q[0] : 8'hxx, 8'h3C);
    chk("echo_rx_ready_back", rx_data_ready, 1);
    nb = 0;
    repeat (5*P) begin
      step();
      if (frame_busy) nb++;
    end
    chk("disabled_busy_cycles", nb, 0);
    chk("disabled_no_done", dones - d0, 0);
    q.delete();
    ch_data = {tbl[0].c1, tbl[0].c0};
    frame_en = 1'b1;
    wait_busy("reenable_start", 3*P, cyc);
    chk("reenable_cyc", cyc, P);
    step();
    chk("send_rx_blocked", rx_data_ready, 0);
    rx_data = 8'hC3;
    rx_data_valid = 1'b1;
    c = 0;
    while (!rx_data_ready && c < 100) begin
      step();
      c++;
    end
    chk("rxsend_ready_seen", rx_data_ready, 1);
    chk("rxsend_after_done", frame_done, 1);
    step();
    rx_data_valid = 1'b0;
    repeat (4) step();
    build_exp(tbl[0]);
    exp_q.push_back(8'hC3);
    cmp_frame("rxsend");
    q.delete();
    d0 = dones;
    o0 = ovrs;
    wait_busy("ovr_start", 2*P, cyc);
    step();
    tx_data_ready = 1'b0;
    repeat (90) step();
    tx_data_ready = 1'b1;
    wait_dones("ovr_first_done", d0 + 1, 100);
    chk("ovr_pulses", ovrs - o0, 1);
    wait_busy("b2b_start", 3, cyc);
    chk("b2b_gap", cyc <= 1, 1);
    wait_dones("b2b_done", d0 + 2, 100);
    repeat (2) step();
    build_exp(tbl[0]);
    for (int i = 0, n = exp_q.size(); i < n; i++) exp_q.push_back(exp_q[i]);
    cmp_frame("b2b");
    q.delete();
    wait_busy("rst_frame_start", 2*P, cyc);
    c = 0;
    while (q.size() < 4 && c < 20) begin
      step();
      c++;
    end
    chk("rst_mid_bytes", q.size(), 4);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", tx_data_valid, 0);
    chk("rst_mid_busy", frame_busy, 0);
    repeat (3) step();
    chk("rst_hold_valid", tx_data_valid, 0);
    sys_rst_n = 1'b1;
    q.delete();
    d0 = dones;
    wait_busy("rst_restart", 3*P, cyc);
    chk("rst_restart_cyc", cyc, P);
    wait_dones("rst_restart_done", d0 + 1, 100);
    repeat (2) step();
    build_exp(tbl[0]);
    cmp_frame("rst_restart");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
